// File: rtl/mem_access_unit_pkg.sv
// Shared types for the load/store path: access width, unit state
// and the width-to-byte-count helper used by the sequencer.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        MW_BYTE    = 2'b00,
        MW_HALF    = 2'b01,
        MW_WORD    = 2'b10,
        MW_ILLEGAL = 2'b11
    } MemWidth;

    typedef enum logic [2:0] {
        MA_IDLE,
        MA_READ,
        MA_READ_LAST,
        MA_WRITE,
        MA_RESP
    } MemAccState;

    function automatic logic [2:0] widthToBytes(input MemWidth w);
        case (w)
            MW_BYTE: widthToBytes = 3'd1;
            MW_HALF: widthToBytes = 3'd2;
            MW_WORD: widthToBytes = 3'd4;
            default: widthToBytes = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load result extension: i_buf (raw little-endian bytes), i_width,
// i_signed in; o_data is the sign/zero-extended 32-bit word.
module load_extend
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] i_buf,
    input  MemWidth     i_width,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = '0;
        case (i_width)
            MW_BYTE: o_data = {{24{i_signed & i_buf[7]}}, i_buf[7:0]};
            MW_HALF: o_data = {{16{i_signed & i_buf[15]}}, i_buf[15:0]};
            MW_WORD: o_data = i_buf;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Byte-serial load/store unit: req_* handshake in, resp_* pulse out,
// mem_* drives a byte-wide RAM with one-cycle read latency.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_width,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    MemAccState        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    MemWidth           r_width;
    logic              r_signed;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf, w_buf_nxt;
    logic [2:0]        r_cnt, w_cnt_nxt, w_cnt_inc, w_nm1;
    logic              w_last, w_accept, w_illegal;
    logic              w_cap_en;
    logic [1:0]        w_cap_idx;
    logic [31:0]       w_ext;
    logic [ADDR_W-1:0] w_addr_inc;

    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [7:0]        r_mem_wdata, w_mem_wdata_nxt;
    logic              r_resp_valid, w_resp_valid_nxt;
    logic              r_resp_err, w_resp_err_nxt;
    logic [31:0]       r_resp_rdata, w_resp_rdata_nxt;

    assign req_ready  = (r_state == MA_IDLE);
    assign w_accept   = req_valid && req_ready;
    assign w_illegal  = (MemWidth'(req_width) == MW_ILLEGAL);
    assign w_nm1      = widthToBytes(r_width) - 3'd1;
    assign w_last     = (r_cnt == w_nm1);
    assign w_cnt_inc  = r_cnt + 3'd1;
    assign w_addr_inc = r_base + ADDR_W'(w_cnt_inc);

    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_wdata  = r_mem_wdata;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;

    // Read data lags its address by one cycle: in READ the byte for
    // r_cnt-1 arrives, in READ_LAST the final byte arrives.
    always_comb begin
        w_cap_en  = 1'b0;
        w_cap_idx = 2'd0;
        if (r_state == MA_READ && r_cnt != 3'd0) begin
            w_cap_en  = 1'b1;
            w_cap_idx = r_cnt[1:0] - 2'd1;
        end else if (r_state == MA_READ_LAST) begin
            w_cap_en  = 1'b1;
            w_cap_idx = w_nm1[1:0];
        end
        w_buf_nxt = r_buf;
        if (w_accept)
            w_buf_nxt = '0;
        else if (w_cap_en)
            w_buf_nxt[{w_cap_idx, 3'b000} +: 8] = mem_rdata;
    end

    // Extension sees the buffer including the byte landing this edge,
    // so the result can be registered straight into resp_rdata.
    load_extend u_ext (
        .i_buf    (w_buf_nxt),
        .i_width  (r_width),
        .i_signed (r_signed),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= MA_IDLE;
            r_base       <= '0;
            r_width      <= MW_BYTE;
            r_signed     <= 1'b0;
            r_wdata      <= '0;
            r_buf        <= '0;
            r_cnt        <= '0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_buf        <= w_buf_nxt;
            r_cnt        <= w_cnt_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            if (w_accept) begin
                r_base   <= req_addr;
                r_width  <= MemWidth'(req_width);
                r_signed <= req_signed;
                r_wdata  <= req_wdata;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            MA_IDLE: begin
                if (w_accept) begin
                    if (w_illegal)      w_state_nxt = MA_RESP;
                    else if (req_write) w_state_nxt = MA_WRITE;
                    else                w_state_nxt = MA_READ;
                end
            end
            MA_READ:      if (w_last) w_state_nxt = MA_READ_LAST;
            MA_READ_LAST: w_state_nxt = MA_RESP;
            MA_WRITE:     if (w_last) w_state_nxt = MA_RESP;
            MA_RESP:      w_state_nxt = MA_IDLE;
            default:      w_state_nxt = MA_IDLE;
        endcase
    end

    // Next values for the registered bus and response outputs.
    always_comb begin
        w_cnt_nxt        = r_cnt;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_we_nxt     = 1'b0;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_resp_valid_nxt = 1'b0;
        w_resp_err_nxt   = 1'b0;
        w_resp_rdata_nxt = '0;
        unique case (r_state)
            MA_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt = '0;
                    if (w_illegal) begin
                        w_resp_valid_nxt = 1'b1;
                        w_resp_err_nxt   = 1'b1;
                    end else begin
                        w_mem_addr_nxt  = req_addr;
                        w_mem_we_nxt    = req_write;
                        w_mem_wdata_nxt = req_wdata[7:0];
                    end
                end
            end
            MA_READ: begin
                w_cnt_nxt = w_cnt_inc;
                if (!w_last)
                    w_mem_addr_nxt = w_addr_inc;
            end
            MA_READ_LAST: begin
                w_resp_valid_nxt = 1'b1;
                w_resp_rdata_nxt = w_ext;
            end
            MA_WRITE: begin
                if (w_last) begin
                    w_resp_valid_nxt = 1'b1;
                end else begin
                    w_cnt_nxt       = w_cnt_inc;
                    w_mem_addr_nxt  = w_addr_inc;
                    w_mem_we_nxt    = 1'b1;
                    w_mem_wdata_nxt = r_wdata[{w_cnt_inc[1:0], 3'b000} +: 8];
                end
            end
            MA_RESP: begin
                w_cnt_nxt = r_cnt;
            end
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
    end

endmodule
